obstacle_scheduler: RTL and testbench

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

---
 rtl/obstacle_scheduler.sv | 119 +++++++++++
 tb/tb_obstacle_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler for the runner game.
// It counts frame ticks between obstacles and offers a registered descriptor to the renderer.
module obstacle_scheduler #(
    parameter int NUM_BITS = 8,
    parameter int MIN_GAP  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                game_over,
    input  logic                tick,
    input  logic [NUM_BITS-1:0] lfsr_data,
    output logic                lfsr_enable,
    output logic                spawn_valid,
    input  logic                spawn_ready,
    output logic [1:0]          spawn_type,
    output logic                bird_high,
    output logic [7:0]          spawn_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SPAWN = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [5:0] MIN_GAP_W = 6'(MIN_GAP);

    state_t     state;
    state_t     state_next;
    logic [5:0] gap;
    logic [5:0] gap_next;
    logic [1:0] type_next;
    logic       bird_next;
    logic [7:0] count_next;
    logic       transfer;
    logic       unused_lfsr;

    assign transfer    = spawn_valid && spawn_ready;
    assign unused_lfsr = ^lfsr_data;

    // Status outputs are decoded from the next state so they are registered
    // yet still track the state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gap         <= 6'd0;
            spawn_valid <= 1'b0;
            spawn_type  <= 2'b00;
            bird_high   <= 1'b0;
            spawn_count <= 8'd0;
            lfsr_enable <= 1'b0;
        end else begin
            state       <= state_next;
            gap         <= gap_next;
            spawn_valid <= (state_next == SPAWN);
            spawn_type  <= type_next;
            bird_high   <= bird_next;
            spawn_count <= count_next;
            lfsr_enable <= (state_next == RUN) || (state_next == SPAWN);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, HALT: begin
                if (game_over)  state_next = HALT;
                else if (start) state_next = RUN;
            end
            RUN: begin
                if (game_over)                 state_next = HALT;
                else if (tick && gap == 6'd0)  state_next = SPAWN;
            end
            SPAWN: begin
                if (game_over)        state_next = HALT;
                else if (spawn_ready) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // A transfer coinciding with game_over is still counted, but skips the gap reload.
    always_comb begin
        gap_next   = gap;
        type_next  = spawn_type;
        bird_next  = bird_high;
        count_next = spawn_count;
        case (state)
            IDLE, HALT: begin
                if (start && !game_over) begin
                    gap_next   = MIN_GAP_W;
                    count_next = 8'd0;
                end
            end
            RUN: begin
                if (!game_over && tick) begin
                    if (gap != 6'd0) begin
                        gap_next = gap - 6'd1;
                    end else begin
                        type_next = lfsr_data[1:0];
                        bird_next = (lfsr_data[1:0] == 2'b11) && lfsr_data[2];
                    end
                end
            end
            SPAWN: begin
                if (transfer) begin
                    if (spawn_count != 8'hFF) count_next = spawn_count + 8'd1;
                    if (!game_over) gap_next = MIN_GAP_W + {2'b00, lfsr_data[7:4]};
                end
            end
            default: begin
                gap_next = gap;
            end
        endcase
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed, table-driven bench for obstacle_scheduler with hand-written
// sequences for saturation and asynchronous reset.
module tb_obstacle_scheduler;

    logic       clk;
    logic       rst;
    logic       start;
    logic       game_over;
    logic       tick;
    logic [7:0] lfsr_data;
    logic       lfsr_enable;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [1:0] spawn_type;
    logic       bird_high;
    logic [7:0] spawn_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       s;
        logic       g;
        logic       t;
        logic       r;
        logic [7:0] d;
        logic       ev;
        logic [1:0] et;
        logic       eb;
        logic [7:0] ec;
        logic       ee;
    } vec_t;

    vec_t vecs[$];

    obstacle_scheduler #(.NUM_BITS(8), .MIN_GAP(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .game_over   (game_over),
        .tick        (tick),
        .lfsr_data   (lfsr_data),
        .lfsr_enable (lfsr_enable),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_type  (spawn_type),
        .bird_high   (bird_high),
        .spawn_count (spawn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and leave time 1 unit past the edge.
    task automatic apply_stimulus(input logic s, input logic g, input logic t,
                                  input logic r, input logic [7:0] d);
        start       = s;
        game_over   = g;
        tick        = t;
        spawn_ready = r;
        lfsr_data   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic s, input logic g, input logic t, input logic r,
                           input logic [7:0] d, input logic ev, input logic [1:0] et,
                           input logic eb, input logic [7:0] ec, input logic ee);
        vec_t v;
        v.s = s; v.g = g; v.t = t; v.r = r; v.d = d;
        v.ev = ev; v.et = et; v.eb = eb; v.ec = ec; v.ee = ee;
        vecs.push_back(v);
    endtask

    initial begin
        bit ok;

        rst = 1'b1; start = 1'b0; game_over = 1'b0; tick = 1'b0;
        spawn_ready = 1'b0; lfsr_data = 8'h00;
        #12;
        check_output("reset valid", 32'(spawn_valid), 32'd0);
        check_output("reset type",  32'(spawn_type),  32'd0);
        check_output("reset bird",  32'(bird_high),   32'd0);
        check_output("reset count", 32'(spawn_count), 32'd0);
        check_output("reset en",    32'(lfsr_enable), 32'd0);
        rst = 1'b0;

        // first spawn on the 9th tick, bird high
        add_vec(1,0,0,0,8'h00, 0,2'd0,0,8'd0,1);
        for (int i = 0; i < 8; i++) add_vec(0,0,1,0,8'h00, 0,2'd0,0,8'd0,1);
        add_vec(0,0,1,0,8'hA7, 1,2'd3,1,8'd0,1);
        // stall: ticks ignored, fields stable
        for (int i = 0; i < 5; i++) add_vec(0,0,1,0,8'hFF, 1,2'd3,1,8'd0,1);
        // transfer with reload 8+3
        add_vec(0,0,0,1,8'h3C, 0,2'd3,1,8'd1,1);
        add_vec(0,0,0,1,8'h00, 0,2'd3,1,8'd1,1);
        for (int i = 0; i < 11; i++)
            add_vec((i == 4), 0, 1, (i == 2), 8'h00, 0,2'd3,1,8'd1,1);
        add_vec(0,0,0,0,8'h00, 0,2'd3,1,8'd1,1);
        add_vec(0,0,1,0,8'h06, 1,2'd2,0,8'd1,1);
        // game_over wins over tick/start but the transfer is still counted
        add_vec(1,1,1,1,8'h00, 0,2'd2,0,8'd2,0);
        add_vec(1,0,0,0,8'h00, 0,2'd2,0,8'd0,1);
        add_vec(0,1,1,0,8'h00, 0,2'd2,0,8'd0,0);
        add_vec(1,1,0,0,8'h00, 0,2'd2,0,8'd0,0);
        add_vec(0,0,1,0,8'h00, 0,2'd2,0,8'd0,0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].s, vecs[i].g, vecs[i].t, vecs[i].r, vecs[i].d);
            check_output($sformatf("vec%0d valid", i), 32'(spawn_valid), 32'(vecs[i].ev));
            check_output($sformatf("vec%0d type",  i), 32'(spawn_type),  32'(vecs[i].et));
            check_output($sformatf("vec%0d bird",  i), 32'(bird_high),   32'(vecs[i].eb));
            check_output($sformatf("vec%0d count", i), 32'(spawn_count), 32'(vecs[i].ec));
            check_output($sformatf("vec%0d en",    i), 32'(lfsr_enable), 32'(vecs[i].ee));
        end

        // saturation over 256 accepted spawns
        apply_stimulus(1,0,0,0,8'h00);
        for (int n = 1; n <= 256; n++) begin
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                apply_stimulus(0,0,1,0,8'h00);
                if (spawn_valid === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("[TB] FAIL sat wait: no spawn_valid within 40 ticks at spawn %0d", n);
                break;
            end
            apply_stimulus(0,0,0,1,8'h00);
            if (n == 1)   check_output("sat count 1",   32'(spawn_count), 32'd1);
            if (n == 255) check_output("sat count 255", 32'(spawn_count), 32'd255);
            if (n == 256) check_output("sat count 256", 32'(spawn_count), 32'd255);
        end

        // asynchronous reset in the middle of SPAWN
        apply_stimulus(0,1,0,0,8'h00);
        apply_stimulus(1,0,0,0,8'h00);
        for (int i = 0; i < 8; i++) apply_stimulus(0,0,1,0,8'h00);
        apply_stimulus(0,0,1,0,8'h03);
        check_output("pre-rst valid", 32'(spawn_valid), 32'd1);
        check_output("pre-rst type",  32'(spawn_type),  32'd3);
        #3 rst = 1'b1;
        #1;
        check_output("async valid", 32'(spawn_valid), 32'd0);
        check_output("async en",    32'(lfsr_enable), 32'd0);
        check_output("async type",  32'(spawn_type),  32'd0);
        check_output("async count", 32'(spawn_count), 32'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus(0,0,1,1,8'h00);
        check_output("idle hold en",    32'(lfsr_enable), 32'd0);
        check_output("idle hold valid", 32'(spawn_valid), 32'd0);
        apply_stimulus(1,1,0,0,8'h00);
        check_output("start+go en", 32'(lfsr_enable), 32'd0);
        apply_stimulus(1,0,0,0,8'h00);
        check_output("restart en",    32'(lfsr_enable), 32'd1);
        check_output("restart count", 32'(spawn_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
